// File: rtl/mem_pkg.sv
// Shared encodings for the memory access unit.
//   readtype_e : load type encoding from the M stage
//   memwrite_e : store size encoding from the M stage
//   state_e    : access FSM states
//   acc_t      : access descriptor captured when an access is accepted
package mem_pkg;

    typedef enum logic [2:0] {
        RT_LW   = 3'b000,
        RT_LB   = 3'b001,
        RT_LBU  = 3'b010,
        RT_LH   = 3'b011,
        RT_LD   = 3'b100,
        RT_LHU  = 3'b101,
        RT_LWU  = 3'b110,
        RT_RSVD = 3'b111
    } readtype_e;

    typedef enum logic [1:0] {
        MW_NONE  = 2'b00,
        MW_BYTE  = 2'b01,
        MW_WORD  = 2'b10,
        MW_DWORD = 2'b11
    } memwrite_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    typedef struct packed {
        logic      is_store;
        readtype_e rtype;
    } acc_t;

    // log2 of the access size in bytes; bit 2 marks an encoding with no defined size
    function automatic logic [2:0] access_size_lg(input logic      is_store,
                                                  input memwrite_e mw,
                                                  input readtype_e rt);
        logic [2:0] lg;
        lg = 3'b100;
        if (is_store) begin
            case (mw)
                MW_BYTE:  lg = 3'd0;
                MW_WORD:  lg = 3'd2;
                MW_DWORD: lg = 3'd3;
                default:  lg = 3'b100;
            endcase
        end else begin
            case (rt)
                RT_LB, RT_LBU: lg = 3'd0;
                RT_LH, RT_LHU: lg = 3'd1;
                RT_LW, RT_LWU: lg = 3'd2;
                RT_LD:         lg = 3'd3;
                default:       lg = 3'b100;
            endcase
        end
        return lg;
    endfunction

endpackage

// File: rtl/load_extend.sv
// Load lane extraction and sign/zero extension (combinational).
//   rdata  : full-width memory read data
//   off    : byte offset of the access within the N-bit word
//   rtype  : load type
//   data_c : right-aligned, extended load result
module load_extend
    import mem_pkg::*;
#(
    parameter int unsigned N = 64
) (
    input  logic [N-1:0]             rdata,
    input  logic [$clog2(N/8)-1:0]   off,
    input  readtype_e                rtype,
    output logic [N-1:0]             data_c
);

    logic [N-1:0] sh;

    // Shift the addressed lane down to bit 0, then extend by load type
    always_comb begin
        sh     = rdata >> {off, 3'b000};
        data_c = sh;
        case (rtype)
            RT_LB:   data_c = N'($signed(sh[7:0]));
            RT_LBU:  data_c = N'(sh[7:0]);
            RT_LH:   data_c = N'($signed(sh[15:0]));
            RT_LHU:  data_c = N'(sh[15:0]);
            RT_LW:   data_c = N'($signed(sh[31:0]));
            RT_LWU:  data_c = N'(sh[31:0]);
            default: data_c = sh;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// Pipeline memory access unit: stalls the pipeline while a load/store from
// the M stage is carried out on a simple req/ready memory port.
//   clk_in, reset           : clock, async active-low reset
//   dataadr, writedata      : access address and right-aligned store data
//   memwriteM, memreadM     : store size / load request
//   readtypeM               : load type
//   stall                   : pipeline freeze (combinational)
//   readdata                : extended load result, valid in the DONE cycle
//   mem_req, mem_we         : memory request / write strobe
//   mem_addr, mem_be        : aligned address, byte enables
//   mem_wdata, mem_rdata    : lane-aligned write data, read data
//   mem_ready               : memory completion strobe
//   err_timeout, err_align  : sticky error flags
module mem_access_unit
    import mem_pkg::*;
#(
    parameter int unsigned N       = 64,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic             clk_in,
    input  logic             reset,
    input  logic [N-1:0]     dataadr,
    input  logic [N-1:0]     writedata,
    input  logic [1:0]       memwriteM,
    input  logic             memreadM,
    input  logic [2:0]       readtypeM,
    output logic             stall,
    output logic [N-1:0]     readdata,
    output logic             mem_req,
    output logic             mem_we,
    output logic [N-1:0]     mem_addr,
    output logic [N/8-1:0]   mem_be,
    output logic [N-1:0]     mem_wdata,
    input  logic [N-1:0]     mem_rdata,
    input  logic             mem_ready,
    output logic             err_timeout,
    output logic             err_align
);

    localparam int unsigned NB = N / 8;
    localparam int unsigned LW = $clog2(NB);
    localparam int unsigned CW = 16;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    state_e        state_q;
    state_e        state_d;
    acc_t          acc_q;
    logic [LW-1:0] off_q;
    logic [CW-1:0] cnt_q;

    logic          access_c;
    logic          is_store_c;
    logic          misalign_c;
    logic          req_tmo_c;
    logic [2:0]    size_c;
    logic [LW-1:0] off_c;
    logic [NB-1:0] be_c;
    logic [N-1:0]  ext_c;

    // Decode the access presented by the M stage; a store wins over a load
    always_comb begin
        access_c   = memreadM || (memwriteM != MW_NONE);
        is_store_c = (memwriteM != MW_NONE);
        size_c     = access_size_lg(is_store_c, memwrite_e'(memwriteM), readtype_e'(readtypeM));
        off_c      = dataadr[LW-1:0];
        // Wider than the bus (ld/sd on N=32) or an undefined size counts as misaligned
        misalign_c = size_c[2]
                  || (32'(size_c[1:0]) > LW)
                  || ((dataadr[2:0] & 3'((4'd1 << size_c[1:0]) - 4'd1)) != 3'd0)
                  || ((N == 32) && !is_store_c && (readtype_e'(readtypeM) == RT_LWU));
        be_c = '0;
        case (size_c[1:0])
            2'd0:    be_c = NB'(1);
            2'd1:    be_c = NB'(3);
            2'd2:    be_c = NB'(15);
            default: be_c = '1;
        endcase
        be_c = be_c << off_c;
    end

    assign req_tmo_c = (cnt_q == CNT_LAST);

    // Next state and stall; stall is forced low while reset is asserted
    always_comb begin
        state_d = state_q;
        stall   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (access_c) begin
                    stall   = 1'b1;
                    state_d = misalign_c ? ST_DONE : ST_REQ;
                end
            end
            ST_REQ: begin
                stall = 1'b1;
                if (mem_ready || req_tmo_c) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        if (!reset) begin
            stall = 1'b0;
        end
    end

    load_extend #(.N(N)) u_load_extend (
        .rdata  (mem_rdata),
        .off    (off_q),
        .rtype  (acc_q.rtype),
        .data_c (ext_c)
    );

    // State, captured access, memory port and result registers
    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            acc_q       <= '0;
            off_q       <= '0;
            cnt_q       <= '0;
            mem_req     <= 1'b0;
            mem_we      <= 1'b0;
            mem_addr    <= '0;
            mem_be      <= '0;
            mem_wdata   <= '0;
            readdata    <= '0;
            err_timeout <= 1'b0;
            err_align   <= 1'b0;
        end else begin
            state_q  <= state_d;
            readdata <= '0;
            case (state_q)
                ST_IDLE: begin
                    if (access_c) begin
                        acc_q.is_store <= is_store_c;
                        acc_q.rtype    <= readtype_e'(readtypeM);
                        off_q          <= off_c;
                        if (misalign_c) begin
                            err_align <= 1'b1;
                        end else begin
                            cnt_q     <= '0;
                            mem_req   <= 1'b1;
                            mem_we    <= is_store_c;
                            mem_addr  <= dataadr & ~N'(NB - 1);
                            mem_be    <= be_c;
                            mem_wdata <= writedata << {off_c, 3'b000};
                        end
                    end
                end
                ST_REQ: begin
                    if (mem_ready || req_tmo_c) begin
                        mem_req <= 1'b0;
                        mem_we  <= 1'b0;
                        mem_be  <= '0;
                        if (mem_ready) begin
                            if (!acc_q.is_store) begin
                                readdata <= ext_c;
                            end
                        end else begin
                            err_timeout <= 1'b1;
                        end
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: the driver pushes expected completions
// and memory requests; monitors pop and compare when the DUT presents them.
module tb_mem_access_unit;

    localparam int unsigned N     = 64;
    localparam int unsigned NB    = N / 8;
    localparam int unsigned TMO   = 8;
    localparam int          NEVER = 1000;

    logic          clk_in = 1'b0;
    logic          reset  = 1'b0;
    logic [N-1:0]  dataadr, writedata, readdata, mem_addr, mem_wdata, mem_rdata;
    logic [1:0]    memwriteM;
    logic          memreadM;
    logic [2:0]    readtypeM;
    logic          stall, mem_req, mem_we, mem_ready, err_timeout, err_align;
    logic [NB-1:0] mem_be;

    always #5 clk_in = ~clk_in;

    mem_access_unit #(.N(N), .TIMEOUT(TMO)) dut (
        .clk_in      (clk_in),
        .reset       (reset),
        .dataadr     (dataadr),
        .writedata   (writedata),
        .memwriteM   (memwriteM),
        .memreadM    (memreadM),
        .readtypeM   (readtypeM),
        .stall       (stall),
        .readdata    (readdata),
        .mem_req     (mem_req),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_be      (mem_be),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata),
        .mem_ready   (mem_ready),
        .err_timeout (err_timeout),
        .err_align   (err_align)
    );

    typedef struct {
        logic [63:0] rd;
        logic        ea;
        logic        et;
        int          stall_cyc;
    } done_exp_t;

    typedef struct {
        logic [63:0] addr;
        logic [7:0]  be;
        logic [63:0] wdata;
        logic        we;
        int          cycles;
    } req_exp_t;

    done_exp_t   done_q[$];
    req_exp_t    req_q[$];
    int          total = 0;
    int          bad   = 0;
    logic        m_ea  = 1'b0;
    logic        m_et  = 1'b0;
    int          cur_delay = 0;
    logic [63:0] cur_rdata = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    function automatic int acc_bytes(input logic st, input logic [1:0] mw, input logic [2:0] rt);
        if (st) return (mw == 2'b01) ? 1 : (mw == 2'b10) ? 4 : 8;
        case (rt)
            3'd1, 3'd2: return 1;
            3'd3, 3'd5: return 2;
            3'd0, 3'd6: return 4;
            default:    return 8;
        endcase
    endfunction

    // Pick the addressed bytes and extend as the load type demands
    function automatic logic [63:0] load_val(input logic [2:0] rt, input logic [63:0] rd, input int off);
        int          b;
        logic [63:0] v;
        logic [63:0] mask;
        logic        sgn;
        b    = acc_bytes(1'b0, 2'b00, rt);
        sgn  = (rt == 3'd0) || (rt == 3'd1) || (rt == 3'd3);
        v    = rd >> (8 * off);
        mask = (b == 8) ? '1 : ((64'd1 << (8 * b)) - 64'd1);
        v    = v & mask;
        if (sgn && v[8 * b - 1]) v = v | ~mask;
        return v;
    endfunction

    function automatic logic [63:0] lane_mask(input logic [7:0] be);
        logic [63:0] m;
        m = '0;
        for (int i = 0; i < 8; i++) if (be[i]) m[8 * i +: 8] = 8'hFF;
        return m;
    endfunction

    // Issue one access, queue its expectations, and wait for its DONE cycle
    task automatic do_access(input logic rd, input logic [1:0] mw, input logic [2:0] rt,
                             input logic [63:0] addr, input logic [63:0] wd,
                             input logic [63:0] rdv, input int dly);
        logic      st;
        int        b;
        int        off;
        logic      mis;
        logic      tmo;
        int        req_cyc;
        int        n;
        done_exp_t de;
        req_exp_t  re;
        st      = (mw != 2'b00);
        b       = acc_bytes(st, mw, rt);
        off     = int'(addr[2:0]);
        mis     = ((addr[2:0] & 3'(b - 1)) != 3'd0);
        tmo     = !mis && (dly >= int'(TMO));
        req_cyc = tmo ? int'(TMO) : dly + 1;
        m_ea    = m_ea | mis;
        m_et    = m_et | tmo;
        de.rd        = (st || mis || tmo) ? 64'd0 : load_val(rt, rdv, off);
        de.ea        = m_ea;
        de.et        = m_et;
        de.stall_cyc = mis ? 1 : 1 + req_cyc;
        done_q.push_back(de);
        if (!mis) begin
            re.addr   = addr & ~64'(NB - 1);
            re.be     = 8'(((1 << b) - 1) << off);
            re.wdata  = wd << (8 * off);
            re.we     = st;
            re.cycles = req_cyc;
            req_q.push_back(re);
        end
        @(posedge clk_in); #1;
        cur_delay = dly;
        cur_rdata = rdv;
        dataadr   = addr;
        writedata = wd;
        memwriteM = mw;
        memreadM  = rd;
        readtypeM = rt;
        n = 0;
        do begin
            @(posedge clk_in); #1;
            n++;
        end while (stall && n < int'(TMO) + 4);
        if (stall) begin
            total++;
            bad++;
            $display("FAIL wait_done: stall still high after %0d cycles, want low", n);
        end
    endtask

    task automatic idle(input int n);
        @(posedge clk_in); #1;
        memreadM  = 1'b0;
        memwriteM = 2'b00;
        repeat (n) @(posedge clk_in);
    endtask

    task automatic rand_batch(input int n, input bit allow_err);
        for (int i = 0; i < n; i++) begin
            logic [1:0]  mw;
            logic        rd;
            logic [2:0]  rt;
            logic [63:0] a;
            int          dly;
            int          b;
            a  = {$urandom, $urandom};
            rt = 3'($urandom_range(0, 6));
            if ($urandom_range(0, 1) == 1) begin
                mw = 2'($urandom_range(1, 3));
                rd = 1'($urandom_range(0, 1));
            end else begin
                mw = 2'b00;
                rd = 1'b1;
            end
            b = acc_bytes(mw != 2'b00, mw, rt);
            if (!allow_err || $urandom_range(0, 3) != 0) a = a & ~64'(b - 1);
            if (allow_err && $urandom_range(0, 7) == 0) dly = NEVER;
            else dly = int'($urandom_range(0, 4));
            do_access(rd, mw, rt, a, {$urandom, $urandom}, {$urandom, $urandom}, dly);
        end
    endtask

    // Memory responder: ready after cur_delay low cycles; stray ready outside requests
    int rc = 0;
    always @(negedge clk_in) begin
        if (mem_req && reset) begin
            if (rc == cur_delay) begin
                mem_ready = 1'b1;
                mem_rdata = cur_rdata;
            end else begin
                mem_ready = 1'b0;
                mem_rdata = {$urandom, $urandom};
            end
            rc++;
        end else begin
            rc        = 0;
            mem_ready = ($urandom_range(0, 3) == 0);
            mem_rdata = {$urandom, $urandom};
        end
    end

    // Completion monitor: the first stall-low sample after a stall run is DONE
    int scnt = 0;
    always @(negedge clk_in) begin
        done_exp_t de;
        if (!reset) begin
            scnt = 0;
        end else if (stall) begin
            scnt++;
        end else if (scnt > 0) begin
            if (done_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL done_unexpected: completion with %0d stall cycles, want none", scnt);
            end else begin
                de = done_q.pop_front();
                chk("readdata", readdata, de.rd);
                chk("err_align", 64'(err_align), 64'(de.ea));
                chk("err_timeout", 64'(err_timeout), 64'(de.et));
                chk("stall_cycles", 64'(scnt), 64'(de.stall_cyc));
            end
            scnt = 0;
        end
    end

    // Memory-side monitor: request fields every REQ cycle, and request length
    int       rcnt    = 0;
    logic     have_re = 1'b0;
    req_exp_t cur_re;
    always @(negedge clk_in) begin
        if (!reset) begin
            rcnt    = 0;
            have_re = 1'b0;
        end else if (mem_req) begin
            if (rcnt == 0) begin
                if (req_q.size() == 0) begin
                    total++;
                    bad++;
                    have_re = 1'b0;
                    $display("FAIL req_unexpected: mem_req at addr %h, want no request", mem_addr);
                end else begin
                    cur_re  = req_q.pop_front();
                    have_re = 1'b1;
                end
            end
            rcnt++;
            if (have_re) begin
                chk("mem_addr", mem_addr, cur_re.addr);
                chk("mem_be", 64'(mem_be), 64'(cur_re.be));
                chk("mem_we", 64'(mem_we), 64'(cur_re.we));
                if (cur_re.we)
                    chk("mem_wdata", mem_wdata & lane_mask(cur_re.be),
                        cur_re.wdata & lane_mask(cur_re.be));
            end
        end else if (rcnt > 0) begin
            if (have_re) chk("req_cycles", 64'(rcnt), 64'(cur_re.cycles));
            rcnt    = 0;
            have_re = 1'b0;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        dataadr   = '0;
        writedata = '0;
        memwriteM = 2'b00;
        memreadM  = 1'b0;
        readtypeM = 3'd0;
        mem_ready = 1'b0;
        mem_rdata = '0;
        repeat (3) @(posedge clk_in);
        #1;
        chk("rst_stall", 64'(stall), 64'd0);
        chk("rst_mem_req", 64'(mem_req), 64'd0);
        chk("rst_mem_we", 64'(mem_we), 64'd0);
        chk("rst_mem_be", 64'(mem_be), 64'd0);
        chk("rst_mem_addr", mem_addr, 64'd0);
        chk("rst_mem_wdata", mem_wdata, 64'd0);
        chk("rst_readdata", readdata, 64'd0);
        chk("rst_err_timeout", 64'(err_timeout), 64'd0);
        chk("rst_err_align", 64'(err_align), 64'd0);
        @(posedge clk_in); #2;
        reset = 1'b1;
        idle(2);

        // lb at ...03, sign bit of the lane set
        do_access(1'b1, 2'b00, 3'd1, 64'hA5A5_0000_1000_0003, 64'd0, 64'h0000_0000_8000_0000, 0);
        // sw 0x12345678 at ...04
        do_access(1'b0, 2'b10, 3'd0, 64'h0000_0000_2000_0004, 64'h0000_0000_1234_5678, 64'd0, 0);
        // lw with mem_ready held low for 5 cycles
        do_access(1'b1, 2'b00, 3'd0, 64'h0000_0000_3000_0010, 64'd0, 64'hCAFE_F00D_8765_4321, 5);
        do_access(1'b1, 2'b00, 3'd4, 64'h0000_0000_3000_0008, 64'd0, 64'hFEDC_BA98_7654_3210, 1);
        do_access(1'b0, 2'b11, 3'd0, 64'h0000_0000_3000_0018, 64'h1122_3344_5566_7788, 64'd0, 2);
        do_access(1'b0, 2'b01, 3'd0, 64'h0000_0000_3000_0007, 64'h0000_0000_0000_00AB, 64'd0, 0);
        do_access(1'b1, 2'b00, 3'd5, 64'h0000_0000_3000_0006, 64'd0, 64'h9ABC_0000_0000_0000, 3);
        do_access(1'b1, 2'b00, 3'd6, 64'h0000_0000_3000_0004, 64'd0, 64'h8000_0001_0000_0000, 0);
        do_access(1'b1, 2'b00, 3'd2, 64'h0000_0000_3000_0005, 64'd0, 64'h0000_F100_0000_0000, 0);
        // load and store together: handled as the store
        do_access(1'b1, 2'b01, 3'd0, 64'h0000_0000_3000_0002, 64'h0000_0000_0000_005A, 64'hFFFF_FFFF_FFFF_FFFF, 1);
        idle(1);
        rand_batch(30, 1'b0);

        // lh at ...01: no request, err_align, one stall cycle
        do_access(1'b1, 2'b00, 3'd3, 64'h0000_0000_4000_0001, 64'd0, 64'd0, 0);
        // mem_ready never arrives: timeout after TMO cycles
        do_access(1'b1, 2'b00, 3'd0, 64'h0000_0000_4000_0020, 64'd0, 64'd0, NEVER);
        idle(1);
        rand_batch(40, 1'b1);
        idle(2);

        // Reset in the middle of an outstanding request
        cur_delay = NEVER;
        begin
            req_exp_t re;
            re.addr   = 64'h0000_0000_5000_0008;
            re.be     = 8'h0F;
            re.wdata  = '0;
            re.we     = 1'b0;
            re.cycles = 0;
            req_q.push_back(re);
        end
        @(posedge clk_in); #1;
        dataadr   = 64'h0000_0000_5000_0008;
        memwriteM = 2'b00;
        memreadM  = 1'b1;
        readtypeM = 3'd0;
        @(posedge clk_in); #1;
        @(posedge clk_in); #1;
        chk("pre_rst_mem_req", 64'(mem_req), 64'd1);
        #2 reset = 1'b0;
        #1;
        chk("mid_rst_mem_req", 64'(mem_req), 64'd0);
        chk("mid_rst_stall", 64'(stall), 64'd0);
        chk("mid_rst_mem_be", 64'(mem_be), 64'd0);
        chk("mid_rst_err_timeout", 64'(err_timeout), 64'd0);
        chk("mid_rst_err_align", 64'(err_align), 64'd0);
        memreadM = 1'b0;
        m_ea     = 1'b0;
        m_et     = 1'b0;
        req_q.delete();
        done_q.delete();
        repeat (2) @(posedge clk_in);
        #2 reset = 1'b1;
        idle(1);
        do_access(1'b1, 2'b00, 3'd0, 64'h0000_0000_6000_000C, 64'd0, 64'h0000_0001_7FFF_FFFF, 1);
        idle(3);

        chk("done_q_empty", 64'(done_q.size()), 64'd0);
        chk("req_q_empty", 64'(req_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 SHALL have parameter N, default 64, meaning data/address width (legal values 32 or 64).
REQ-002 SHALL have parameter TIMEOUT, default 255, meaning maximum wait cycles for mem_ready before abort (1..65535).
REQ-003 SHALL have ports: clk_in  in  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have ports: reset  in  1  asynchronous, active-low reset.
REQ-005 SHALL have ports: dataadr  in  N  byte address from pipeline M stage.
REQ-006 SHALL have ports: writedata  in  N  store data, right-aligned.
REQ-007 SHALL have ports: memwriteM  in  2  store size: 00 none, 01 byte, 10 word, 11 dword.
REQ-008 SHALL have ports: memreadM  in  1  load request.
REQ-009 SHALL have ports: readtypeM  in  3  load type: 000 lw, 001 lb, 010 lbu, 011 lh, 100 ld, 101 lhu, 110 lwu.
REQ-010 SHALL have ports: stall  out  1  freezes all pipeline stages while high.
REQ-011 SHALL have ports: readdata  out  N  extended load result, valid in the DONE cycle.
REQ-012 SHALL have ports: mem_req, mem_we  out  1 each  memory request and write strobe.
REQ-013 SHALL have ports: mem_addr  out  N  N/8-aligned address.
REQ-014 SHALL have ports: mem_be  out  N/8  byte enables.
REQ-015 SHALL have ports: mem_wdata  out  N  lane-aligned store data.
REQ-016 SHALL have ports: mem_rdata  in  N  memory read data.
REQ-017 SHALL have ports: mem_ready  in  1  completion strobe.
REQ-018 SHALL have ports: err_timeout, err_align  out  1 each  sticky error flags.

Function
REQ-019 SHALL implement FSM states IDLE, REQ, DONE.
REQ-020 In IDLE, memreadM=1 or memwriteM!=00 SHALL raise stall combinationally in the same cycle, register address, data and type, and move to REQ.
REQ-021 In REQ, mem_req SHALL be 1, driven only from registered values that hold stable until mem_ready; mem_we=1 for stores.
REQ-022 mem_ready=1 in REQ SHALL capture mem_rdata and move to DONE; mem_ready outside REQ SHALL be ignored.
REQ-023 In DONE, stall SHALL be 0 and readdata valid for exactly one cycle, then return to IDLE without re-triggering on the same (now advancing) access.
REQ-024 Minimum access latency SHALL be 2 cycles of stall (detect, REQ with mem_ready=1), with DONE on the third cycle.
REQ-025 Byte lane SHALL be selected by dataadr[log2(N/8)-1:0]; mem_be: byte=1 lane, word=4 lanes, dword=all lanes.
REQ-026 Loads SHALL sign-extend for lb/lh/lw and zero-extend for lbu/lhu/lwu; ld SHALL pass through unchanged.
REQ-027 Misaligned access (half on odd address, word on non-multiple-of-4, dword on non-multiple-of-8) SHALL issue no mem_req, set err_align, return readdata=0, and take IDLE->DONE.
REQ-028 ld, lwu, and memwriteM=11 with N=32 SHALL be treated as misaligned.
REQ-029 A counter SHALL count cycles spent in REQ; reaching TIMEOUT without mem_ready SHALL drop mem_req, set err_timeout, give readdata=0, and go to DONE.
REQ-030 The counter SHALL be cleared on every entry to REQ.
REQ-031 memreadM and memwriteM both active SHALL be treated as a store; the load is ignored.
REQ-032 Error flags SHALL stay set until reset.

Reset
REQ-033 Reset low SHALL immediately force IDLE, stall=0, mem_req=0, mem_we=0, mem_be=0, mem_addr=0, mem_wdata=0, readdata=0, counter=0, err_*=0, including mid-access; an in-flight request is abandoned.

Structure
REQ-034 Readtype and memwrite encodings and the state enum SHALL live in shared package mem_pkg.
REQ-035 Lane extraction and extension SHALL be a combinational sub-module load_extend (parameter N).

Verification
REQ-036 N=64, lb at 0x...03, mem_rdata=0x00000000_80000000 -> readdata=0xFFFF_FFFF_FFFF_FF80, stall high 2 cycles.
REQ-037 N=64, sw 0x12345678 at 0x...04 -> mem_be=0xF0, mem_wdata[63:32]=0x12345678, mem_we=1.
REQ-038 mem_ready held low 5 cycles -> mem_req, mem_addr and mem_wdata stable for 6 cycles, stall released one cycle after mem_ready.
REQ-039 TIMEOUT=4, mem_ready never asserted -> err_timeout=1 after 4 REQ cycles, readdata=0, stall drops.
REQ-040 lh at 0x...01 -> no mem_req, err_align=1, one stall cycle.
REQ-041 Reset asserted in REQ -> mem_req=0 and stall=0 immediately; new lw after reset completes normally.
